// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: buffers up to four fetched instructions per cycle
// (with their PCs) in a circular queue and presents the two oldest entries
// to decode each cycle. A flush discards everything on a branch redirect.
module inst_fetch_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_inst0,
    input  logic [31:0]      in_inst1,
    input  logic [31:0]      in_inst2,
    input  logic [31:0]      in_inst3,
    input  logic [2:0]       in_count,
    input  logic [31:0]      in_pc,
    output logic             in_ready,
    output logic [31:0]      out_inst0,
    output logic [31:0]      out_inst1,
    output logic [31:0]      out_pc0,
    output logic [31:0]      out_pc1,
    output logic             out_valid0,
    output logic             out_valid1,
    input  logic             out_ready,
    output logic [PTR_W:0]   occupancy
);

    // A full fetch group needs four free slots, so accept only at or below this count.
    localparam logic [PTR_W:0] READY_LIMIT = (PTR_W + 1)'(DEPTH - 4);
    localparam logic [PTR_W:0] FULL_COUNT  = (PTR_W + 1)'(DEPTH);

    // Storage: instruction word and its PC per entry; contents need no reset.
    logic [31:0] inst_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];

    // Queue bookkeeping; pointers wrap naturally modulo DEPTH.
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail_next;
    logic [PTR_W:0]   count_next;
    logic [PTR_W-1:0] head_plus1;

    // Per-cycle transfer sizes.
    logic [2:0] group_size;
    logic [2:0] push_n;
    logic [1:0] pop_n;

    // Incoming group, indexed by position in program order.
    logic [31:0] group_inst [4];
    logic [31:0] group_pc   [4];

    assign group_inst[0] = in_inst0;
    assign group_inst[1] = in_inst1;
    assign group_inst[2] = in_inst2;
    assign group_inst[3] = in_inst3;

    // Derive each group member's PC from the group base (wraps modulo 2^32).
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            group_pc[i] = in_pc + (32'(i) << 2);
        end
    end

    // Clamp the valid count to four; encodings 5-7 mean a full group.
    always_comb begin
        group_size = in_count;
        if (in_count > 3'd4) begin
            group_size = 3'd4;
        end
    end

    // Ready depends on the registered count only, never on out_ready.
    always_comb begin
        in_ready = (count <= READY_LIMIT);
    end

    // Number of entries actually written this cycle; a flush suppresses the push.
    always_comb begin
        push_n = 3'd0;
        if (in_valid && in_ready && !flush) begin
            push_n = group_size;
        end
    end

    // Present the two oldest entries; a flush hides them for the redirect cycle.
    always_comb begin
        head_plus1 = head + PTR_W'(1);
        out_inst0  = inst_mem[head];
        out_pc0    = pc_mem[head];
        out_inst1  = inst_mem[head_plus1];
        out_pc1    = pc_mem[head_plus1];
        out_valid0 = (count >= (PTR_W + 1)'(1)) && !flush;
        out_valid1 = (count >= (PTR_W + 1)'(2)) && !flush;
        occupancy  = count;
    end

    // Decode takes every valid slot when it signals ready.
    always_comb begin
        pop_n = 2'd0;
        if (out_ready) begin
            pop_n = {1'b0, out_valid0} + {1'b0, out_valid1};
        end
    end

    // Advance pointers and count; flush empties the queue outright.
    always_comb begin
        head_next  = head;
        tail_next  = tail;
        count_next = count;
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            head_next  = head + PTR_W'(pop_n);
            tail_next  = tail + PTR_W'(push_n);
            count_next = count + (PTR_W + 1)'(push_n) - (PTR_W + 1)'(pop_n);
        end
    end

    // Write the accepted group members into consecutive slots starting at tail.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < push_n) begin
                inst_mem[tail + PTR_W'(i)] <= group_inst[i];
                pc_mem[tail + PTR_W'(i)]   <= group_pc[i];
            end
        end
    end

    // Pointer and count registers; reset drops all queued instructions immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
        end
    end

    // The count can never exceed the queue size.
    count_in_range: assert property (@(posedge clk) disable iff (reset)
        count <= FULL_COUNT);

    // Below full, the count must match the pointer distance.
    count_matches_ptrs: assert property (@(posedge clk) disable iff (reset)
        (count < FULL_COUNT) |-> (count == {1'b0, PTR_W'(tail - head)}));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue: directed fetch groups feed a scoreboard,
// and a negedge monitor checks every instruction decode consumes.
module tb_inst_fetch_queue;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           flush;
    logic           in_valid;
    logic [31:0]    in_inst0;
    logic [31:0]    in_inst1;
    logic [31:0]    in_inst2;
    logic [31:0]    in_inst3;
    logic [2:0]     in_count;
    logic [31:0]    in_pc;
    logic           in_ready;
    logic [31:0]    out_inst0;
    logic [31:0]    out_inst1;
    logic [31:0]    out_pc0;
    logic [31:0]    out_pc1;
    logic           out_valid0;
    logic           out_valid1;
    logic           out_ready;
    logic [PTR_W:0] occupancy;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } sb_entry_t;

    sb_entry_t sb[$];
    int errors = 0;
    int checks = 0;
    int mcount = 0;
    int pend_push = 0;
    int pend_pop = 0;
    bit pend_flush = 1'b0;

    // Hand-computed expectations for the fill and wrap sequences.
    int occ_fill[4]  = '{4, 8, 12, 16};
    int rdy_fill[4]  = '{1, 1, 1, 0};
    int occ_wrap[7]  = '{4, 6, 8, 10, 12, 14, 12};

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_inst0(in_inst0),
        .in_inst1(in_inst1),
        .in_inst2(in_inst2),
        .in_inst3(in_inst3),
        .in_count(in_count),
        .in_pc(in_pc),
        .in_ready(in_ready),
        .out_inst0(out_inst0),
        .out_inst1(out_inst1),
        .out_pc0(out_pc0),
        .out_pc1(out_pc1),
        .out_valid0(out_valid0),
        .out_valid1(out_valid1),
        .out_ready(out_ready),
        .occupancy(occupancy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic popCompare(input string slot, input logic [31:0] inst, input logic [31:0] pc);
        sb_entry_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_unexpected: got inst 0x%08h, expected no entry", slot, inst);
        end else begin
            e = sb.pop_front();
            checkOutput({slot, "_inst"}, inst, e.inst);
            checkOutput({slot, "_pc"}, pc, e.pc);
        end
    endtask

    // Drive one cycle of inputs and record what the queue should accept.
    task automatic driveInputs(input bit v, input int cnt, input logic [31:0] pc,
                               input logic [31:0] base, input bit rdy, input bit fl);
        int n;
        sb_entry_t e;
        in_valid  = v;
        in_count  = 3'(cnt);
        in_pc     = pc;
        in_inst0  = base;
        in_inst1  = base + 32'd1;
        in_inst2  = base + 32'd2;
        in_inst3  = base + 32'd3;
        out_ready = rdy;
        flush     = fl;
        n = (cnt > 4) ? 4 : cnt;
        pend_flush = fl;
        pend_push  = 0;
        pend_pop   = 0;
        if (fl) begin
            sb.delete();
        end else begin
            pend_push = (v && mcount <= DEPTH - 4) ? n : 0;
            pend_pop  = rdy ? ((mcount >= 2) ? 2 : mcount) : 0;
            for (int k = 0; k < pend_push; k++) begin
                e.inst = base + 32'(k);
                e.pc   = pc + 32'(4 * k);
                sb.push_back(e);
            end
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        if (pend_flush) mcount = 0;
        else mcount = mcount + pend_push - pend_pop;
        #1;
    endtask

    task automatic applyStimulus(input bit v, input int cnt, input logic [31:0] pc,
                                 input logic [31:0] base, input bit rdy, input bit fl);
        driveInputs(v, cnt, pc, base, rdy, fl);
        stepClock();
    endtask

    // Monitor: checks handshake outputs and pops the scoreboard on each consumed slot.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("mon_in_ready", 32'(in_ready), 32'(mcount <= DEPTH - 4));
            checkOutput("mon_out_valid0", 32'(out_valid0), 32'((mcount >= 1) && !flush));
            checkOutput("mon_out_valid1", 32'(out_valid1), 32'((mcount >= 2) && !flush));
            if (out_ready && out_valid0) popCompare("slot0", out_inst0, out_pc0);
            if (out_ready && out_valid1) popCompare("slot1", out_inst1, out_pc1);
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_count = 3'd0;
        in_pc = 32'd0;
        in_inst0 = 32'd0;
        in_inst1 = 32'd0;
        in_inst2 = 32'd0;
        in_inst3 = 32'd0;
        out_ready = 1'b0;
        #1;
        checkOutput("reset_occupancy", 32'(occupancy), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid0", 32'(out_valid0), 32'd0);
        checkOutput("reset_out_valid1", 32'(out_valid1), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // Basic push of four, decode stalled.
        applyStimulus(1, 4, 32'h1000, 32'hA000_0000, 0, 0);
        checkOutput("t1_occupancy", 32'(occupancy), 32'd4);
        checkOutput("t1_valid0", 32'(out_valid0), 32'd1);
        checkOutput("t1_valid1", 32'(out_valid1), 32'd1);
        checkOutput("t1_inst0", out_inst0, 32'hA000_0000);
        checkOutput("t1_pc0", out_pc0, 32'h1000);
        checkOutput("t1_inst1", out_inst1, 32'hA000_0001);
        checkOutput("t1_pc1", out_pc1, 32'h1004);

        // Drain two per cycle.
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 0);
        checkOutput("t2_occupancy_a", 32'(occupancy), 32'd2);
        checkOutput("t2_inst0", out_inst0, 32'hA000_0002);
        checkOutput("t2_pc0", out_pc0, 32'h1008);
        checkOutput("t2_inst1", out_inst1, 32'hA000_0003);
        checkOutput("t2_pc1", out_pc1, 32'h100C);
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 0);
        checkOutput("t2_occupancy_b", 32'(occupancy), 32'd0);
        checkOutput("t2_valid0", 32'(out_valid0), 32'd0);

        // Fill to DEPTH; in_ready drops only once the count passes 12.
        for (int g = 0; g < 4; g++) begin
            applyStimulus(1, 4, 32'h2000 + 32'(16 * g), 32'hB000_0000 + 32'(g << 8), 0, 0);
            checkOutput("t3_occupancy", 32'(occupancy), 32'(occ_fill[g]));
            checkOutput("t3_in_ready", 32'(in_ready), 32'(rdy_fill[g]));
        end
        applyStimulus(1, 4, 32'h3000, 32'hBF00_0000, 0, 0);
        applyStimulus(1, 4, 32'h3000, 32'hBF00_0000, 0, 0);
        checkOutput("t3_held_occupancy", 32'(occupancy), 32'd16);
        for (int c = 0; c < 8; c++) applyStimulus(0, 0, 32'h0, 32'h0, 1, 0);
        checkOutput("t3_drained", 32'(occupancy), 32'd0);

        // Push four / pop two until the tail wraps; first group uses count 7 (clamped).
        for (int c = 0; c < 7; c++) begin
            applyStimulus(1, (c == 0) ? 7 : 4, 32'h4000 + 32'(16 * c), 32'hC000_0000 + 32'(c << 8), 1, 0);
            checkOutput("t4_occupancy", 32'(occupancy), 32'(occ_wrap[c]));
        end
        for (int c = 0; c < 6; c++) applyStimulus(0, 0, 32'h0, 32'h0, 1, 0);
        checkOutput("t4_drained", 32'(occupancy), 32'd0);

        // Zero-count group is a legal no-op.
        applyStimulus(1, 0, 32'h5000, 32'hD000_0000, 1, 0);
        checkOutput("t4_zero_count", 32'(occupancy), 32'd0);

        // Simultaneous push of three and pop with a single entry queued.
        applyStimulus(1, 1, 32'h6000, 32'hE000_0000, 0, 0);
        checkOutput("t5_occupancy_a", 32'(occupancy), 32'd1);
        driveInputs(1, 3, 32'h7000, 32'hE100_0000, 1, 0);
        #1;
        checkOutput("t5_valid0", 32'(out_valid0), 32'd1);
        checkOutput("t5_valid1", 32'(out_valid1), 32'd0);
        stepClock();
        checkOutput("t5_occupancy_b", 32'(occupancy), 32'd3);
        checkOutput("t5_inst0", out_inst0, 32'hE100_0000);
        checkOutput("t5_pc1", out_pc1, 32'h7004);
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 0);
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 0);
        checkOutput("t5_drained", 32'(occupancy), 32'd0);

        // Flush with ten queued and a group offered in the same cycle.
        applyStimulus(1, 4, 32'h8000, 32'hF000_0000, 0, 0);
        applyStimulus(1, 4, 32'h8010, 32'hF100_0000, 0, 0);
        applyStimulus(1, 2, 32'h8020, 32'hF200_0000, 0, 0);
        checkOutput("t6_occupancy_a", 32'(occupancy), 32'd10);
        driveInputs(1, 4, 32'h8800, 32'hF800_0000, 1, 1);
        #1;
        checkOutput("t6_flush_valid0", 32'(out_valid0), 32'd0);
        checkOutput("t6_flush_valid1", 32'(out_valid1), 32'd0);
        checkOutput("t6_flush_in_ready", 32'(in_ready), 32'd1);
        stepClock();
        checkOutput("t6_occupancy_b", 32'(occupancy), 32'd0);
        checkOutput("t6_post_valid0", 32'(out_valid0), 32'd0);
        applyStimulus(1, 2, 32'h9000, 32'h9000_0000, 0, 0);
        checkOutput("t6_refill_occ", 32'(occupancy), 32'd2);
        checkOutput("t6_refill_inst0", out_inst0, 32'h9000_0000);
        checkOutput("t6_refill_pc0", out_pc0, 32'h9000);
        checkOutput("t6_refill_inst1", out_inst1, 32'h9000_0001);
        checkOutput("t6_refill_pc1", out_pc1, 32'h9004);

        // Asynchronous reset in the middle of a push.
        driveInputs(1, 4, 32'hA000, 32'h7000_0000, 0, 0);
        #2 reset = 1'b1;
        #1;
        checkOutput("t6_reset_occupancy", 32'(occupancy), 32'd0);
        checkOutput("t6_reset_valid0", 32'(out_valid0), 32'd0);
        checkOutput("t6_reset_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        mcount = 0;
        pend_push = 0;
        pend_pop = 0;
        pend_flush = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;

        // Queue works normally after reset.
        applyStimulus(1, 4, 32'hB000, 32'h6000_0000, 0, 0);
        checkOutput("t6_after_reset_occ", 32'(occupancy), 32'd4);
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 0);
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 0);
        checkOutput("t6_final_occ", 32'(occupancy), 32'd0);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction buffer directly downstream of the instruction cache fetch output.
- Accepts a group of 0-4 instructions per cycle, along with a valid count and the group's starting PC, into a circular queue.
- Presents up to 2 oldest instructions per cycle to the decode stage.
- Decouples 4-wide fetch from 2-wide decode and supports a pipeline flush on redirect.

Parameters:
- DEPTH, 16, queue entries; power of 2, minimum 8.
- PTR_W, 4, log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  discard all queued instructions (branch redirect).
- in_valid  in  1  fetch group present this cycle.
- in_inst0..in_inst3  in  32 each  fetched instructions, program order, inst0 oldest.
- in_count  in  3  number of valid instructions in the group: 0-4; values 5-7 are treated as 4.
- in_pc  in  32  PC of in_inst0.
- in_ready  out  1  queue can accept a full 4-instruction group.
- out_inst0, out_inst1  out  32 each  oldest and second-oldest queued instruction.
- out_pc0, out_pc1  out  32 each  PCs of those instructions.
- out_valid0, out_valid1  out  1 each  slot holds a valid instruction.
- out_ready  in  1  decode consumes all asserted out_valid slots this cycle.
- occupancy  out  PTR_W+1  current entry count.

Behaviour:
Storage and arithmetic:
- Per entry: 32-bit instruction plus 32-bit PC. Entry i of a group gets PC = in_pc + 4*i, modulo 2^32.
- head, tail: PTR_W-bit pointers that wrap naturally modulo DEPTH.
- count: PTR_W+1 bits, range 0..DEPTH.

Reset (asynchronous, active-high):
- head = tail = count = 0; storage contents are don't-care.
- Outputs during and after reset: out_valid0 = out_valid1 = 0, in_ready = 1, occupancy = 0.
- Reset asserted mid-operation drops everything immediately.

in_ready:
- Combinational: in_ready = (count <= DEPTH-4).
- Depends on the registered count only, never on out_ready. There is no combinational path from out_ready to in_ready.

Push:
- push_n = (in_valid & in_ready & ~flush) ? min(in_count, 4) : 0.
- Writes push_n entries at tail..tail+push_n-1, wrapping past DEPTH-1 to 0.
- tail advances by push_n.
- If in_valid is asserted while in_ready = 0, the group is ignored. Upstream must hold it.
- in_count = 0 with in_valid = 1 is a legal no-op.

Output and pop:
- Outputs are combinational reads of entries head and head+1 (wrapped).
- out_valid0 = (count >= 1) & ~flush; out_valid1 = (count >= 2) & ~flush.
- pop_n = out_ready ? (out_valid0 + out_valid1) : 0. head advances by pop_n.
- Latency: an instruction pushed on edge N is visible on the outputs in the cycle after edge N, one cycle minimum. There is no same-cycle bypass.

Simultaneous push and pop:
- Pop sees pre-edge contents only.
- count_next = count + push_n - pop_n.
- Push and pop never collide on an entry because in_ready guarantees 4 free slots.

Flush:
- Highest priority after reset.
- On the edge: head = tail = count = 0; the push and pop of that cycle are both suppressed.
- out_valid* are forced to 0 combinationally during the flush cycle.
- in_ready is unaffected by flush in that cycle.

Full and empty:
- count = 0: both out_valid are 0, and out_ready is ignored.
- count = 1: only slot 0 is valid.
- count cannot exceed DEPTH, by construction.

Invariants (assertions):
- count == (tail - head) mod DEPTH whenever count < DEPTH.
- count <= DEPTH at all times.

Test Plan:
1. Reset, then push in_count=4, in_pc=0x1000, insts A,B,C,D, with out_ready=0 -> next cycle occupancy=4, out_inst0=A (pc 0x1000), out_inst1=B (pc 0x1004), both valid.
2. From 1, out_ready=1 for 2 cycles, no push -> C/0x1008 and D/0x100C appear, then occupancy=0, out_valid0=0.
3. Four pushes of 4 with out_ready=0 -> after the 4th push occupancy=16; in_ready goes low after the 1st push beyond count 12 (i.e. at count=16). A 5th group held with in_valid=1 is not written.
4. Wrap-around: cycle push 4/pop 2 until tail passes entry 15 -> FIFO order and PCs are preserved across the wrap; occupancy tracks count + 4 - 2 per cycle.
5. Simultaneous push of 3 (in_count=3) and pop of 2 with count=1 -> the pop yields only 1 entry (out_valid1=0); count_next = 1 + 3 - 1 = 3.
6. flush asserted with count=10 and in_valid=1 -> that cycle out_valid*=0; next cycle occupancy=0 and the flush-cycle group is dropped. Asynchronous reset mid-push -> occupancy=0 immediately.
